// File: rtl/writeback_stage_if.sv
// MEM/WB handshake and pipeline bus between the memory stage (master) and writeback (slave).
interface writeback_stage_if #(
  parameter int WIDTH   = 32,
  parameter int REGADDR = 5
);
  logic               mem_valid;
  logic               mem_ready;
  logic               stall;
  logic               flush;
  logic [REGADDR-1:0] mem_rd;
  logic               mem_regwrite;
  logic               mem_memtoreg;
  logic [2:0]         mem_loadtype;
  logic [1:0]         mem_addrlo;
  logic [WIDTH-1:0]   mem_aluout;
  logic [WIDTH-1:0]   mem_readdata;

  modport master (
    output mem_valid, stall, flush, mem_rd, mem_regwrite, mem_memtoreg,
           mem_loadtype, mem_addrlo, mem_aluout, mem_readdata,
    input  mem_ready
  );

  modport slave (
    input  mem_valid, stall, flush, mem_rd, mem_regwrite, mem_memtoreg,
           mem_loadtype, mem_addrlo, mem_aluout, mem_readdata,
    output mem_ready
  );
endinterface

// File: rtl/writeback_stage.sv
// MIPS writeback stage: MEM/WB register, big-endian load formatting, illegal-load
// suppression, register-file write port and a retired-instruction counter.
module writeback_stage #(
  parameter int WIDTH   = 32,
  parameter int REGADDR = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  writeback_stage_if.slave   mem,
  output logic [REGADDR-1:0] rd,
  output logic [WIDTH-1:0]   writedata,
  output logic               regwrite,
  output logic               wb_valid,
  output logic               exc_misaligned,
  output logic [31:0]        retired_count
);

  logic             accept;
  logic             illegal;
  logic             misaligned;
  logic [7:0]       load_byte;
  logic [15:0]      load_half;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] next_data;

  assign mem.mem_ready = !mem.stall;
  assign accept        = mem.mem_valid && !mem.stall && !mem.flush;

  // Byte lane 0 is the most significant byte (big-endian addressing).
  always_comb begin
    load_byte = '0;
    load_half = '0;
    load_data = '0;
    illegal   = 1'b0;
    case (mem.mem_addrlo)
      2'd0:    load_byte = mem.mem_readdata[WIDTH-1  -: 8];
      2'd1:    load_byte = mem.mem_readdata[WIDTH-9  -: 8];
      2'd2:    load_byte = mem.mem_readdata[WIDTH-17 -: 8];
      default: load_byte = mem.mem_readdata[WIDTH-25 -: 8];
    endcase
    load_half = mem.mem_addrlo[1] ? mem.mem_readdata[WIDTH-17 -: 16]
                                  : mem.mem_readdata[WIDTH-1  -: 16];
    case (mem.mem_loadtype)
      3'b000: begin
        illegal   = (mem.mem_addrlo != 2'd0);
        load_data = mem.mem_readdata;
      end
      3'b001:  load_data = {{(WIDTH-8){load_byte[7]}}, load_byte};
      3'b010:  load_data = {{(WIDTH-8){1'b0}}, load_byte};
      3'b011: begin
        illegal   = mem.mem_addrlo[0];
        load_data = {{(WIDTH-16){load_half[15]}}, load_half};
      end
      3'b100: begin
        illegal   = mem.mem_addrlo[0];
        load_data = {{(WIDTH-16){1'b0}}, load_half};
      end
      default: illegal = 1'b1;
    endcase
  end

  // Load faults only matter when the load result is actually selected.
  always_comb begin
    misaligned = mem.mem_memtoreg && illegal;
    if (!mem.mem_memtoreg)
      next_data = mem.mem_aluout;
    else if (illegal)
      next_data = '0;
    else
      next_data = load_data;
  end

  // regwrite is resolved at capture so it is a clean single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd             <= '0;
      writedata      <= '0;
      regwrite       <= 1'b0;
      wb_valid       <= 1'b0;
      exc_misaligned <= 1'b0;
      retired_count  <= 32'd0;
    end else begin
      if (wb_valid && !exc_misaligned)
        retired_count <= retired_count + 32'd1;
      wb_valid       <= accept;
      exc_misaligned <= accept && misaligned;
      regwrite       <= accept && mem.mem_regwrite && (mem.mem_rd != '0) && !misaligned;
      if (accept) begin
        rd        <= mem.mem_rd;
        writedata <= next_data;
      end
    end
  end

endmodule
